i2c_frame_decoder: RTL
======================

Name: i2c_frame_decoder

Overview:
- Consumes the start/stop/data strobes from the I2C line-phy stage, plus the SDA level aligned with them.
- Assembles 9-bit slots (8 data bits MSB-first, then the ACK bit) into bytes.
- Tags the first byte of each frame as the address byte, extracts R/W, and flags an address match against OWN_ADDR.
- Feeds the byte-level overwrite/monitor logic downstream with a one-cycle byte_valid pulse per completed byte, plus frame-boundary and error pulses.

Parameters:
- OWN_ADDR, 7'h50: 7-bit slave address compared against the address byte.
- IDX_W, 4: width of byte_index; the index saturates at 2^IDX_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle strobe: START or repeated START detected
- stop  in  1  one-cycle strobe: STOP detected
- data  in  1  one-cycle strobe: SCL rising edge (bit sample point)
- sda  in  1  SDA level, valid in the cycle data is high
- byte_valid  out  1  one-cycle pulse: byte plus ACK slot complete
- byte_data  out  8  assembled byte, MSB received first
- byte_is_addr  out  1  byte_data is the address byte of the frame
- byte_ack  out  1  SDA value in the 9th slot (0 = ACK, 1 = NACK)
- byte_index  out  IDX_W  position in the frame; address byte = 0
- rw  out  1  R/W bit of the current frame (1 = read)
- addr_match  out  1  address byte[7:1] == OWN_ADDR for the current frame
- frame_active  out  1  high between START and STOP
- frame_done  out  1  one-cycle pulse when a frame ends (STOP or repeated START)
- frame_err  out  1  one-cycle pulse when a frame ends off a byte boundary

Behaviour:
- Reset:
  - All outputs 0; state IDLE; bit_cnt 0; shift register 0; first-byte flag 0.
  - Reset mid-frame aborts silently, with no frame_done or frame_err pulse.
- States:
  - IDLE: no frame.
  - BITS: receiving data bits; bit_cnt 0..7.
  - ACKBIT: waiting for the 9th SCL rising edge.
- Event priority per cycle: start > stop > data. Lower-priority strobes in the same cycle are ignored.
- start, any state:
  - Enter BITS with bit_cnt=0, first=1, byte_index=0, frame_active=1.
  - If already active (repeated START): pulse frame_done the next cycle; also pulse frame_err if state is ACKBIT or bit_cnt!=0.
  - rw and addr_match hold until the new address byte completes.
- stop:
  - In IDLE: ignored.
  - Otherwise: go IDLE, frame_active=0, pulse frame_done; also pulse frame_err if state is ACKBIT or bit_cnt!=0.
  - rw and addr_match retain their last values.
- data:
  - In IDLE: ignored.
  - In BITS: shift = {shift[6:0], sda}; bit_cnt++. After the 8th bit go to ACKBIT.
- data in ACKBIT, in the next cycle:
  - byte_valid=1; byte_data=shift; byte_ack=sda; byte_is_addr=first.
  - byte_index holds the index of the byte just completed.
  - If first: rw=shift[0] and addr_match=(shift[7:1]==OWN_ADDR), both updated in the same cycle as byte_valid.
  - Then first=0, bit_cnt=0, state BITS, and byte_index increments (saturating) after the pulse.
- Latency: byte_valid rises 1 clk after the 9th data strobe; frame_done/frame_err rise 1 clk after the start/stop strobe.
- byte_data, byte_ack and byte_is_addr hold between pulses.
- NACK does not alter sequencing; bytes continue to be decoded until STOP or START.
- No back-pressure: the consumer must accept byte_valid in the cycle it is asserted.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum {IDLE, BITS, ACKBIT}
  - I2C_ACK=1'b0, I2C_NACK=1'b1
  - BITS_PER_BYTE=8
  - I2C_RW_READ=1'b1
- The same package is reused by the phy and by the overwrite logic.
- No sub-module: the shift register, bit counter and FSM are small enough to stay inline.

Test Plan:
- Write frame: START, 0xA0+ACK, 0x12+ACK, 0x34+NACK, STOP →
  - 3 byte_valid pulses: (A0, addr, idx0, ack0), (12, idx1, ack0), (34, idx2, ack1).
  - rw=0, addr_match=1, frame_done=1, frame_err=0.
- Foreign read: START, 0x43 (addr 0x21, R) + NACK, STOP → addr_match=0, rw=1, one byte_valid, frame_done.
- Repeated START: START, 0xA0+ACK, 0x05+ACK, START, 0xA1+ACK, STOP →
  - frame_done pulses twice, frame_err never.
  - After the second address byte: rw=1, byte_index restarts at 0.
- STOP after 3 bits of a data byte → frame_done and frame_err both pulse, no byte_valid, frame_active=0.
- 9 data strobes with sda=1 and no preceding START → no byte_valid, frame_active stays 0.
- rst asserted after 5 address bits → all outputs 0 immediately with no frame_done. A following complete frame then decodes normally from byte_index 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the line phy, the frame decoder and the byte-level overwrite logic.
// Contents: frame decoder state encoding, ACK/NACK bit levels, byte width, R/W bit polarity.
// No ports; import with i2c_pkg::*.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BITS   = 2'd1,
        ACKBIT = 2'd2
    } i2c_state_e;

    localparam logic I2C_ACK       = 1'b0;
    localparam logic I2C_NACK      = 1'b1;
    localparam int   BITS_PER_BYTE = 8;
    localparam logic I2C_RW_READ   = 1'b1;

endpackage

// File: rtl/i2c_frame_decoder.sv
// Turns phy start/stop/data strobes plus SDA into bytes, with address/R-W decode and frame pulses.
// Ports: clk/rst (async, active-high); start/stop/data strobes and sda in; byte_* byte report,
//        rw/addr_match frame info, frame_active level, frame_done/frame_err pulses out. No back-pressure.
module i2c_frame_decoder
    import i2c_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR = 7'h50,
    parameter int         IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             data,
    input  logic             sda,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic             byte_is_addr,
    output logic             byte_ack,
    output logic [IDX_W-1:0] byte_index,
    output logic             rw,
    output logic             addr_match,
    output logic             frame_active,
    output logic             frame_done,
    output logic             frame_err
);

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    i2c_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             first_q, first_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_is_addr_q, byte_is_addr_d;
    logic             byte_ack_q, byte_ack_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rw_q, rw_d;
    logic             match_q, match_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             off_boundary;

    // A frame that ends anywhere other than the first data bit of a slot is truncated.
    assign off_boundary = (state_q == ACKBIT) || (bit_cnt_q != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'd0;
            first_q        <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= 8'd0;
            byte_is_addr_q <= 1'b0;
            byte_ack_q     <= 1'b0;
            idx_q          <= '0;
            rw_q           <= 1'b0;
            match_q        <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            first_q        <= first_d;
            byte_valid_q   <= byte_valid_d;
            byte_data_q    <= byte_data_d;
            byte_is_addr_q <= byte_is_addr_d;
            byte_ack_q     <= byte_ack_d;
            idx_q          <= idx_d;
            rw_q           <= rw_d;
            match_q        <= match_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        first_d        = first_q;
        byte_valid_d   = 1'b0;
        byte_data_d    = byte_data_q;
        byte_is_addr_d = byte_is_addr_q;
        byte_ack_d     = byte_ack_q;
        idx_d          = idx_q;
        rw_d           = rw_q;
        match_d        = match_q;
        done_d         = 1'b0;
        err_d          = 1'b0;

        // The index advances the cycle after the byte pulse so the pulse reports the completed byte.
        if (byte_valid_q && (idx_q != {IDX_W{1'b1}})) begin
            idx_d = idx_q + 1'b1;
        end

        // start beats stop beats data; lower-priority strobes in the same cycle are dropped.
        if (start) begin
            if (state_q != IDLE) begin
                done_d = 1'b1;
                err_d  = off_boundary;
            end
            state_d   = BITS;
            bit_cnt_d = 3'd0;
            first_d   = 1'b1;
            idx_d     = '0;
        end else if (stop) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = off_boundary;
            end
        end else if (data) begin
            unique case (state_q)
                BITS: begin
                    shift_d = {shift_q[6:0], sda};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ACKBIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ACKBIT: begin
                    byte_valid_d   = 1'b1;
                    byte_data_d    = shift_q;
                    byte_ack_d     = sda;
                    byte_is_addr_d = first_q;
                    // rw/addr_match change only on an address byte, so a repeated START keeps
                    // reporting the previous frame until the new address is in.
                    if (first_q) begin
                        rw_d    = shift_q[0];
                        match_d = (shift_q[7:1] == OWN_ADDR);
                    end
                    first_d   = 1'b0;
                    bit_cnt_d = 3'd0;
                    state_d   = BITS;
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_valid   = byte_valid_q;
    assign byte_data    = byte_data_q;
    assign byte_is_addr = byte_is_addr_q;
    assign byte_ack     = byte_ack_q;
    assign byte_index   = idx_q;
    assign rw           = rw_q;
    assign addr_match   = match_q;
    assign frame_active = (state_q != IDLE);
    assign frame_done   = done_q;
    assign frame_err    = err_q;

endmodule
